store_trace_fifo: RTL
=====================

# store_trace_fifo

Downstream observer for the CPU top level: samples the data-memory store bus (`memwrite`, `dataadr`, `writedata`) every cycle, queues each store in a small FIFO, and drains entries through a valid/ready port to a debug sink (UART or display driver). It also raises a sticky `done` flag when the end-of-program store (a configurable data value to a configurable address) appears on the bus. It is purely passive: it never stalls the CPU, and it drops stores it cannot buffer.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, at least 2.
- `DONE_ADDR`, 32'd84: store address that signals program completion.
- `DONE_DATA`, 32'd7: store data that signals program completion.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `memwrite`  in  1  store strobe from the CPU. Each cycle it is high counts as one store.
- `dataadr`  in  32  store byte address.
- `writedata`  in  32  store data.
- `out_valid`  out  1  head entry is available.
- `out_ready`  in  1  sink accepts the head entry this cycle.
- `out_addr`  out  32  head entry address.
- `out_data`  out  32  head entry data.
- `count`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `overflow`  out  1  sticky: at least one store was dropped.
- `drop_cnt`  out  8  number of dropped stores; saturates at 255.
- `done`  out  1  sticky: the completion store was seen.

## Operation
- Storage: DEPTH×64-bit array holding {addr, data}.
  - Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - Occupancy is tracked by `count`, not by pointer comparison.
- `pop` = `out_valid && out_ready`.
  - Advances the read pointer and decrements `count`.
- `push` = `memwrite && (count < DEPTH || pop)`.
  - Writes {dataadr, writedata} at the write pointer, advances it, and increments `count`.
- Push and pop in the same cycle: `count` is unchanged and both pointers advance.
  - This applies when full: the pop frees the slot, so the store is accepted and nothing is dropped.
- Drop = `memwrite && count == DEPTH && !pop`.
  - The store is discarded.
  - `overflow` is set to 1.
  - `drop_cnt` increments unless it is already 255.
- `done` is set when `memwrite && dataadr == DONE_ADDR && writedata == DONE_DATA`.
  - This is independent of FIFO state: it is set even if that store is dropped.
  - It stays set until `rst`.
- `out_valid` = (`count != 0`).
  - `out_addr`/`out_data` show the head entry, first-word-fall-through.
  - While `out_valid` = 0 their value is don't-care, but they must not be X after reset.
- There is no combinational path from `memwrite` to `out_valid`: an empty FIFO shows a new entry one cycle after the push.
- `out_ready` while empty has no effect.

## Timing
- Reset, synchronous on the `clk` edge with `rst` = 1:
  - Both pointers = 0, `count` = 0, `out_valid` = 0.
  - `overflow` = 0, `drop_cnt` = 0, `done` = 0.
  - `out_addr` = `out_data` = 0, so the storage array must be cleared.
  - A `memwrite` in the reset cycle is ignored, both for push and for `done`.
- Reset mid-operation discards all queued entries. The first post-reset store lands at entry 0.
- Latency: store on edge N produces `out_valid` = 1 after edge N, with that entry at the head if the FIFO was empty.
- Throughput: one push and one pop per cycle, sustained indefinitely with `out_ready` held high.
- Handshake:
  - The sink may hold `out_ready` at any level; data changes only after an accepted pop.
  - `out_valid` never drops without a pop or a reset.
- The CPU-side memories are clocked on the inverted clock. This block samples the store bus on the rising edge, when `memwrite`/`dataadr`/`writedata` from the MEM stage are stable.

## Test plan
- Reset and idle:
  - Assert `rst` for 2 cycles, then hold `memwrite` = 0 for 5 cycles.
  - Required: `count` = 0, `out_valid` = 0, `overflow` = 0, `drop_cnt` = 0, `done` = 0 throughout.
- Ordered drain:
  - With `out_ready` = 0, store (0x10, 0xA), (0x14, 0xB), (0x18, 0xC) on consecutive cycles, giving `count` = 3. Then raise `out_ready`.
  - Required: heads appear in order 0x10/0xA, 0x14/0xB, 0x18/0xC, one per cycle. `out_valid` = 0 on the 4th cycle.
- Full plus overflow:
  - With `out_ready` = 0, issue DEPTH + 3 stores, data = 1, 2, …
  - Required: `count` = DEPTH, `overflow` = 1, `drop_cnt` = 3. The drain yields data 1..DEPTH only.
- Simultaneous push/pop at full:
  - Fill to DEPTH, then in one cycle raise `out_ready` = 1 and store (0x40, 0x99).
  - Required: `count` stays DEPTH and `drop_cnt` is unchanged. The 0x40/0x99 entry is the last one drained.
- Wrap-around:
  - Stream 3×DEPTH stores with `out_ready` = 1 continuously.
  - Required: every entry emerges in order with no loss, and `count` never exceeds 1.
- Done detection:
  - Store (84, 6): `done` stays 0.
  - Store (80, 7): `done` stays 0.
  - Store (84, 7) while the FIFO is full and `out_ready` = 0: `done` = 1 after that edge, and `drop_cnt` increments.
  - Assert `rst`: `done` = 0.

Source files
------------

// File: rtl/store_trace_fifo.sv
// Passive store-bus tracer. It captures every CPU data-memory store into a small
// first-word-fall-through FIFO and drains the entries through a valid/ready port.
// It also flags the end-of-program store and counts the stores it had to drop.
module store_trace_fifo #(
    parameter int          DEPTH     = 8,
    parameter logic [31:0] DONE_ADDR = 32'd84,
    parameter logic [31:0] DONE_DATA = 32'd7
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_memwrite,
    input  logic [31:0]              i_dataadr,
    input  logic [31:0]              i_writedata,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic [31:0]              o_out_addr,
    output logic [31:0]              o_out_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overflow,
    output logic [7:0]               o_drop_cnt,
    output logic                     o_done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } entry_t;

    entry_t          r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_overflow;
    logic [7:0]      r_drop_cnt;
    logic            r_done;

    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;
    logic            w_done_hit;
    entry_t          w_head;

    assign w_full     = (r_count == CW'(DEPTH));
    assign w_pop      = (r_count != '0) && i_out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the store.
    assign w_push     = i_memwrite && (!w_full || w_pop);
    assign w_drop     = i_memwrite && w_full && !w_pop;
    assign w_done_hit = i_memwrite && (i_dataadr == DONE_ADDR) && (i_writedata == DONE_DATA);

    // Storage is cleared on reset so the head outputs are never X.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= '{addr: i_dataadr, data: i_writedata};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
            r_done     <= 1'b0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != 8'hFF) begin
                    r_drop_cnt <= r_drop_cnt + 8'd1;
                end
            end
            // Completion is detected on the bus itself, whether or not the store was kept.
            if (w_done_hit) begin
                r_done <= 1'b1;
            end
        end
    end

    assign w_head      = r_mem[r_rd_ptr];
    assign o_out_valid = (r_count != '0);
    assign o_out_addr  = w_head.addr;
    assign o_out_data  = w_head.data;
    assign o_count     = r_count;
    assign o_overflow  = r_overflow;
    assign o_drop_cnt  = r_drop_cnt;
    assign o_done      = r_done;

endmodule
